// File: rtl/addr_seq_ctrl.sv
// addr_seq_ctrl: walks LUT indices first_idx..last_idx. For each index it
// fetches a base address from an external LUT and issues BURST_LEN memory
// beats with valid/ready handshaking.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, first_idx,      sequence request and index range (sampled in IDLE)
//   last_idx
//   abort                  synchronous cancel, no done pulse
//   lut_index / lut_addr   external LUT lookup (lut_addr is combinational)
//   mem_addr, mem_valid,   beat address and handshake
//   mem_ready
//   busy, done             status: not idle / one-cycle completion pulse
module addr_seq_ctrl #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned ADDR_W    = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        first_idx,
  input  logic [3:0]        last_idx,
  input  logic              abort,
  output logic [3:0]        lut_index,
  input  logic [ADDR_W-1:0] lut_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned BEAT_W = 4;
  localparam int unsigned OFF_W  = ADDR_W - 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
  logic [IDX_W-1:0]    end_idx_q, end_idx_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_valid_q, mem_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                accept_c;
  logic                abort_c;
  logic                last_beat_c;
  logic [OFF_W-1:0]    off_sum_c;

  assign accept_c    = mem_valid_q & mem_ready;
  assign abort_c     = abort & (state_q != S_IDLE);
  assign last_beat_c = accept_c & (beat_q == LAST_BEAT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      // An empty range (first > last) is detected on the latched indices
      S_LOAD:  state_d = (cur_idx_q > end_idx_q) ? S_DONE : S_BURST;
      S_BURST: begin
        if (last_beat_c) begin
          state_d = (cur_idx_q == end_idx_q) ? S_DONE : S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_c) state_d = S_IDLE;
  end

  // Datapath next values: index range, LUT base and beat counter
  always_comb begin
    cur_idx_d = cur_idx_q;
    end_idx_d = end_idx_q;
    base_d    = base_q;
    beat_d    = beat_q;
    if (!abort_c) begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            cur_idx_d = first_idx;
            end_idx_d = last_idx;
          end
        end
        S_LOAD: begin
          base_d = lut_addr;
          beat_d = '0;
        end
        S_BURST: begin
          if (last_beat_c) begin
            beat_d = '0;
            // Index saturates at end_idx, so 15 never wraps to 0
            if (cur_idx_q != end_idx_q) cur_idx_d = cur_idx_q + IDX_W'(1);
          end else if (accept_c) begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output next values, derived from the next state so outputs are flops
  always_comb begin
    mem_valid_d = (state_d == S_BURST);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    // Offset wraps inside the bank; bank field is carried from the base
    off_sum_c   = base_d[OFF_W-1:0] + OFF_W'(beat_d);
    mem_addr_d  = '0;
    if (mem_valid_d) mem_addr_d = {base_d[ADDR_W-1:ADDR_W-2], off_sum_c};
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_idx_q   <= '0;
      end_idx_q   <= '0;
      base_q      <= '0;
      beat_q      <= '0;
      mem_addr_q  <= '0;
      mem_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cur_idx_q   <= cur_idx_d;
      end_idx_q   <= end_idx_d;
      base_q      <= base_d;
      beat_q      <= beat_d;
      mem_addr_q  <= mem_addr_d;
      mem_valid_q <= mem_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign lut_index = cur_idx_q;
  assign mem_addr  = mem_addr_q;
  assign mem_valid = mem_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// Self-checking bench for addr_seq_ctrl (BURST_LEN=4, ADDR_W=14): directed
// table vectors, hand-written abort/reset sequences and randomized runs
// compared against a queue-based reference of the expected beat addresses.
module tb_addr_seq_ctrl;

  localparam int unsigned BL = 4;
  localparam int unsigned AW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    first_idx = '0;
  logic [3:0]    last_idx = '0;
  logic          abort = 1'b0;
  logic [3:0]    lut_index;
  logic [AW-1:0] lut_addr;
  logic [AW-1:0] mem_addr;
  logic          mem_valid;
  logic          mem_ready = 1'b1;
  logic          busy;
  logic          done;
  bit            stub_lut = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] got_q[$];

  addr_seq_ctrl #(.BURST_LEN(BL), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .first_idx (first_idx),
    .last_idx  (last_idx),
    .abort     (abort),
    .lut_index (lut_index),
    .lut_addr  (lut_addr),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] lut_fn(input logic [3:0] idx);
    case (idx)
      4'd2:    return 14'h1040;
      4'd3:    return 14'h3000;
      4'd14:   return 14'h000E;
      4'd15:   return 14'h3060;
      default: return 14'(32'(idx) * 32'h0123 + 32'h0800);
    endcase
  endfunction

  always_comb lut_addr = stub_lut ? 14'h3FFE : lut_fn(lut_index);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: every index in range contributes BL beats at base+b within its bank
  function automatic void build_exp(input int f, input int l, input bit stb);
    logic [AW-1:0] base;
    exp_q.delete();
    for (int i = f; i <= l; i++) begin
      base = stb ? 14'h3FFE : lut_fn(4'(i));
      for (int b = 0; b < int'(BL); b++)
        exp_q.push_back({base[13:12], 12'(base[11:0] + 12'(b))});
    end
  endfunction

  // Runs one sequence from IDLE; reports done cycle (start edge = cycle 0)
  task automatic run_seq(input logic [3:0] f, input logic [3:0] l, input bit stb,
                         input bit rnd_ready, output int done_cyc, output int first_v);
    int n_done = 0;
    bit prev_v = 0, prev_acc = 0;
    logic [AW-1:0] prev_a = '0;
    bit acc;
    done_cyc = -1;
    first_v = -1;
    stub_lut = stb;
    got_q.delete();
    build_exp(int'(f), int'(l), stb);
    @(negedge clk);
    start = 1'b1; first_idx = f; last_idx = l;
    @(posedge clk);
    for (int cyc = 1; cyc < 300; cyc++) begin
      @(negedge clk);
      mem_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      // Extra start requests while busy must be ignored
      start = busy && ($urandom_range(0, 3) == 0);
      first_idx = 4'($urandom); last_idx = 4'($urandom);
      if (!mem_valid) chk("addr_zero_when_idle", 32'(mem_addr), 32'h0);
      if (prev_v && !prev_acc) begin
        chk("valid_held", 32'(mem_valid), 32'h1);
        chk("addr_held", 32'(mem_addr), 32'(prev_a));
      end
      if (mem_valid && first_v < 0) first_v = cyc;
      acc = mem_valid && mem_ready;
      if (acc) got_q.push_back(mem_addr);
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      prev_v = mem_valid; prev_acc = acc; prev_a = mem_addr;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    start = 1'b0;
    mem_ready = 1'b1;
    chk("done_pulses", 32'(n_done), 32'h1);
    chk("busy_after", 32'(busy), 32'h0);
    chk("beat_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("beat_addr", 32'(got_q[i]), 32'(exp_q[i]));
    chk("final_lut_index", 32'(lut_index), (f <= l) ? 32'(l) : 32'(f));
  endtask

  typedef struct {
    logic [3:0]    first;
    logic [3:0]    last;
    bit            stub;
    int            n_beats;
    logic [AW-1:0] a_first;
    logic [AW-1:0] a_last;
    int            done_cyc;
  } vec_t;

  vec_t vecs[5];
  int dc, fv;

  initial begin
    vecs[0] = '{4'd2,  4'd2,  1'b0, 4, 14'h1040, 14'h1043, 6};
    vecs[1] = '{4'd14, 4'd15, 1'b0, 8, 14'h000E, 14'h3063, 11};
    vecs[2] = '{4'd5,  4'd3,  1'b0, 0, 14'h0,    14'h0,    2};
    vecs[3] = '{4'd0,  4'd0,  1'b1, 4, 14'h3FFE, 14'h3001, 6};
    vecs[4] = '{4'd15, 4'd15, 1'b0, 4, 14'h3060, 14'h3063, 6};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_valid", 32'(mem_valid), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_lut_index", 32'(lut_index), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed vectors with mem_ready held high
    for (int v = 0; v < 5; v++) begin
      run_seq(vecs[v].first, vecs[v].last, vecs[v].stub, 1'b0, dc, fv);
      chk("vec_done_cycle", 32'(dc), 32'(vecs[v].done_cyc));
      chk("vec_n_beats", 32'(got_q.size()), 32'(vecs[v].n_beats));
      if (vecs[v].n_beats > 0 && got_q.size() > 0) begin
        chk("vec_first_valid_cycle", 32'(fv), 32'h2);
        chk("vec_first_addr", 32'(got_q[0]), 32'(vecs[v].a_first));
        chk("vec_last_addr", 32'(got_q[got_q.size()-1]), 32'(vecs[v].a_last));
      end else begin
        chk("vec_no_valid", 32'(fv), 32'hFFFF_FFFF);
      end
    end

    // Index 3 with random backpressure
    for (int r = 0; r < 3; r++) begin
      run_seq(4'd3, 4'd3, 1'b0, 1'b1, dc, fv);
      chk("bp_beats", 32'(got_q.size()), 32'h4);
    end

    // Abort during the second beat
    stub_lut = 1'b0;
    @(negedge clk);
    start = 1'b1; first_idx = 4'd2; last_idx = 4'd2;
    @(posedge clk);
    @(negedge clk); start = 1'b0;            // cycle 1: LOAD
    @(negedge clk);                          // cycle 2: first beat
    chk("abort_beat0", 32'(mem_addr), 32'h1040);
    @(negedge clk);                          // cycle 3: second beat
    chk("abort_beat1", 32'(mem_addr), 32'h1041);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", 32'(mem_valid), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_addr", 32'(mem_addr), 32'h0);
    begin
      int seen = 0;
      repeat (4) begin
        @(negedge clk);
        if (done) seen++;
      end
      chk("abort_no_done", 32'(seen), 32'h0);
    end
    run_seq(4'd2, 4'd2, 1'b0, 1'b0, dc, fv);
    chk("after_abort_done_cycle", 32'(dc), 32'h6);

    // Reset asserted mid-burst
    @(negedge clk);
    start = 1'b1; first_idx = 4'd14; last_idx = 4'd15;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(mem_valid), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_addr", 32'(mem_addr), 32'h0);
    chk("midrst_lut_index", 32'(lut_index), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      repeat (5) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      chk("midrst_quiet", 32'(seen), 32'h0);
    end
    run_seq(4'd14, 4'd15, 1'b0, 1'b0, dc, fv);
    chk("after_rst_done_cycle", 32'(dc), 32'd11);

    // Randomized ranges, LUT mode and backpressure
    for (int r = 0; r < 20; r++) begin
      logic [3:0] f, l;
      f = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) l = 4'($urandom_range(0, 15));
      else l = 4'((int'(f) + int'($urandom_range(0, 2)) > 15) ? 15 : int'(f) + int'($urandom_range(0, 2)));
      run_seq(f, l, ($urandom_range(0, 3) == 0), 1'b1, dc, fv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
